// File: rtl/uart_send_fifo_if.sv
// Byte-in / serial-out signal bundle for uart_send_fifo.
// The master side drives the receiver handshake; the slave side is the transmitter.
interface uart_send_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                        rx_int;
    logic [7:0]                  data_in;
    logic                        data_tx;
    logic                        tx_busy;
    logic                        fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;

    modport master (
        output rx_int, data_in,
        input  data_tx, tx_busy, fifo_full, fifo_count, overflow
    );

    modport slave (
        input  rx_int, data_in,
        output data_tx, tx_busy, fifo_full, fifo_count, overflow
    );
endinterface

// File: rtl/uart_send_fifo.sv
// Buffered 8N1 transmitter: captures a byte on each receiver end-of-frame edge,
// queues it in a circular FIFO and shifts it out LSB first at CLK_FREQ/BAUD.
module uart_send_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input logic            clk,
    input logic            rst,
    uart_send_fifo_if.slave bus
);
    localparam int          BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_int_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    shift_r;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic          data_tx_r;
    logic          tx_busy_r;
    logic          overflow_r;

    logic push;
    logic pop;
    logic full;
    logic accept;
    logic baud_tick;

    assign push      = rx_int_d & ~bus.rx_int;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = (state == IDLE) && (count != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign accept    = push & (~full | pop);
    assign baud_tick = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_int_d   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            rx_int_d   <= bus.rx_int;
            overflow_r <= push & full & ~pop;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // data_tx is loaded with the level of the state being entered, so the
    // registered line changes on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_tx_r <= 1'b1;
            tx_busy_r <= 1'b0;
            shift_r   <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    data_tx_r <= 1'b1;
                    if (pop) begin
                        shift_r   <= mem[rd_ptr];
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        data_tx_r <= 1'b0;
                        tx_busy_r <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        baud_cnt  <= '0;
                        data_tx_r <= shift_r[0];
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        shift_r  <= shift_r >> 1;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            data_tx_r <= 1'b1;
                            state     <= STOP;
                        end else begin
                            data_tx_r <= shift_r[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        baud_cnt  <= '0;
                        tx_busy_r <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    data_tx_r <= 1'b1;
                    tx_busy_r <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_tx    = data_tx_r;
    assign bus.tx_busy    = tx_busy_r;
    assign bus.fifo_full  = full;
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_uart_send_fifo.sv
// Self-checking bench for uart_send_fifo: a line decoder rebuilds transmitted bytes,
// which are compared against the bytes the bench pushed.
module tb_uart_send_fifo;
    logic clk;
    logic rst;

    uart_send_fifo_if #(.FIFO_DEPTH(4)) bus ();

    uart_send_fifo #(
        .CLK_FREQ  (1_000_000),
        .BAUD      (100_000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    logic [7:0]  got_q[$];
    int unsigned got_t[$];
    logic [7:0]  exp_q[$];

    int          ovf_n;
    logic        full_seen;
    int          peak;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.overflow === 1'b1) ovf_n++;
        if (bus.fifo_full === 1'b1) full_seen = 1'b1;
        if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line decoder: 10 bit periods of 10 cycles, each period must hold one level.
    initial begin : line_mon
        logic [7:0]  mb;
        logic        good;
        logic        aborted;
        int unsigned t0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.data_tx === 1'b0) begin
                t0      = cyc;
                mb      = '0;
                good    = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < 100 && !aborted; k++) begin
                    int p;
                    int c;
                    p = k / 10;
                    c = k % 10;
                    if (k != 0) @(negedge clk);
                    if (rst !== 1'b0) aborted = 1'b1;
                    else if (p == 0) begin
                        if (bus.data_tx !== 1'b0) good = 1'b0;
                    end else if (p == 9) begin
                        if (bus.data_tx !== 1'b1) good = 1'b0;
                    end else if (c == 0) mb[p-1] = bus.data_tx;
                    else if (bus.data_tx !== mb[p-1]) good = 1'b0;
                end
                if (!aborted) begin
                    chk("frame_shape", {31'd0, good}, 32'd1);
                    got_q.push_back(mb);
                    got_t.push_back(t0);
                end
            end
        end
    end

    // Leaves the call at the negedge of the push cycle (rx_int just dropped).
    task automatic push_byte(input logic [7:0] b, input int hi);
        bus.rx_int  = 1'b1;
        bus.data_in = 8'($urandom);
        repeat (hi) @(negedge clk);
        bus.rx_int  = 1'b0;
        bus.data_in = b;
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_frames(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic clear_trackers();
        ovf_n     = 0;
        full_seen = 1'b0;
        peak      = 0;
    endtask

    initial begin : stim
        logic [7:0] b;
        int         n;
        int unsigned t_s;

        rst         = 1'b1;
        bus.rx_int  = 1'b1;
        bus.data_in = 8'($urandom);
        clear_trackers();

        // Reset with rx_int held high: no push until a fresh falling edge.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data_tx", bus.data_tx, 1);
        chk("rst_tx_busy", bus.tx_busy, 0);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_fifo_full", bus.fifo_full, 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_count", bus.fifo_count, 0);
        b = 8'($urandom);
        bus.rx_int  = 1'b0;
        bus.data_in = b;
        exp_q.push_back(b);
        @(negedge clk);
        chk("rst_edge_push", bus.fifo_count, 1);
        wait_frames(1);
        check_frames("rst_push");

        // Single byte 0xA5: start bit two cycles after the edge, busy for 100 cycles.
        push_byte(8'hA5, 5);
        exp_q.push_back(8'hA5);
        @(negedge clk);
        chk("single_e1_count", bus.fifo_count, 1);
        chk("single_e1_line", bus.data_tx, 1);
        @(negedge clk);
        chk("single_e2_line", bus.data_tx, 0);
        chk("single_e2_count", bus.fifo_count, 0);
        n = 0;
        while (bus.tx_busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("single_busy_len", n, 100);
        wait_frames(1);
        check_frames("single");

        // Back-to-back: three pushes four cycles apart.
        clear_trackers();
        for (int i = 1; i <= 3; i++) begin
            push_byte(8'(i), 2);
            exp_q.push_back(8'(i));
            repeat (2) @(negedge clk);
        end
        wait_frames(3);
        chk("b2b_peak", peak, 2);
        chk("b2b_end_count", bus.fifo_count, 0);
        if (got_t.size() >= 3) begin
            chk("b2b_gap1", got_t[1] - got_t[0], 101);
            chk("b2b_gap2", got_t[2] - got_t[1], 101);
        end else begin
            chk("b2b_frames", got_t.size(), 3);
        end
        check_frames("b2b");

        // Overflow: six pushes two cycles apart; the sixth is dropped.
        clear_trackers();
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h10 + 8'(i), 1);
            exp_q.push_back(8'h10 + 8'(i));
            @(negedge clk);
        end
        push_byte(8'h15, 1);
        @(negedge clk);
        chk("ovf_pulse", bus.overflow, 1);
        chk("ovf_full", bus.fifo_full, 1);
        chk("ovf_count", bus.fifo_count, 4);
        @(negedge clk);
        chk("ovf_pulse_end", bus.overflow, 0);
        wait_frames(5);
        repeat (150) @(negedge clk);
        chk("ovf_pulses", ovf_n, 1);
        chk("ovf_full_seen", full_seen, 1);
        check_frames("ovf");

        // Reset during data bit 4 of 0xFF with two more bytes queued.
        push_byte(8'hFF, 2);
        n = 0;
        while (bus.data_tx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        t_s = cyc;
        push_byte(8'($urandom), 2);
        @(negedge clk);
        push_byte(8'($urandom), 2);
        @(negedge clk);
        n = 0;
        while (cyc < t_s + 55 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_pre_count", bus.fifo_count, 2);
        chk("mid_pre_busy", bus.tx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_line", bus.data_tx, 1);
        chk("mid_rst_count", bus.fifo_count, 0);
        chk("mid_rst_busy", bus.tx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("mid_after_count", bus.fifo_count, 0);
        check_frames("mid_rst");

        // Pointer wrap: ten sequential bytes, one per frame time.
        clear_trackers();
        for (int i = 0; i < 10; i++) begin
            push_byte(8'(i), 2);
            exp_q.push_back(8'(i));
            repeat (110) @(negedge clk);
        end
        wait_frames(10);
        chk("wrap_no_ovf", ovf_n, 0);
        check_frames("wrap");

        // Random bytes at random spacing; five bytes can never overflow depth 4.
        clear_trackers();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            push_byte(b, $urandom_range(1, 3));
            exp_q.push_back(b);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        wait_frames(5);
        chk("rand_no_ovf", ovf_n, 0);
        chk("rand_end_count", bus.fifo_count, 0);
        check_frames("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
